muldiv_sequencer: RTL and testbench

//  Sequences the shared multiplier and divider units for mult/div instructions.

---
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divider for mult/div instructions and commits results to HI/LO.
// Optional WAIT timeout abort is enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               req_ready,
  output logic               busy,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               mult_start,
  output logic               div_start,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_result,
  input  logic               div_done,
  input  logic [WIDTH-1:0]   div_quotient,
  input  logic [WIDTH-1:0]   div_remainder,
  output logic               hi_write,
  output logic               lo_write,
  output logic [WIDTH-1:0]   hi_in,
  output logic [WIDTH-1:0]   lo_in,
  output logic               op_done,
  output logic               dbz_exc,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_WB,
    S_EXC
  } state_e;

  if (CNT_W < 1 || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("muldiv_sequencer: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_e             state_q, state_d;
  logic               op_q;
  logic [WIDTH-1:0]   op_a_q, op_b_q;
  logic               req_ready_q, busy_q;
  logic               mult_start_q, div_start_q;
  logic               hi_write_q, lo_write_q, op_done_q;
  logic [WIDTH-1:0]   hi_in_q, lo_in_q;
  logic               dbz_exc_q, timeout_err_q;
  logic               done_sel;
  logic               tout;

`ifdef MULDIV_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Only the launched unit's done is honoured; the other unit may share the bus.
  assign done_sel = op_q ? div_done : mult_done;

  always_comb begin
    state_d = state_q;
    tout    = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
`ifdef MULDIV_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (op_q && (op_b_q == '0)) state_d = S_EXC;
        else                        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_sel) begin
          state_d = S_WB;
        end else begin
`ifdef MULDIV_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TMO) begin
            tout    = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end
      S_WB:    state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from state_d so each pulse lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      mult_start_q  <= 1'b0;
      div_start_q   <= 1'b0;
      hi_write_q    <= 1'b0;
      lo_write_q    <= 1'b0;
      op_done_q     <= 1'b0;
      hi_in_q       <= '0;
      lo_in_q       <= '0;
      dbz_exc_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= (state_d == S_IDLE);
      busy_q       <= (state_d != S_IDLE);
      if (state_q == S_IDLE && req_valid) begin
        op_q   <= req_op;
        op_a_q <= req_a;
        op_b_q <= req_b;
      end
      // Start pulses are decided from the request itself so they appear during LAUNCH.
      mult_start_q <= (state_q == S_IDLE) && req_valid && !req_op;
      div_start_q  <= (state_q == S_IDLE) && req_valid && req_op && (req_b != '0);
      hi_write_q   <= (state_d == S_WB);
      lo_write_q   <= (state_d == S_WB);
      op_done_q    <= (state_d == S_WB);
      if (state_d == S_WB) begin
        hi_in_q <= op_q ? div_remainder : mult_result[2*WIDTH-1:WIDTH];
        lo_in_q <= op_q ? div_quotient  : mult_result[WIDTH-1:0];
      end else begin
        hi_in_q <= '0;
        lo_in_q <= '0;
      end
      dbz_exc_q     <= (state_d == S_EXC);
      timeout_err_q <= tout;
`ifdef MULDIV_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign mult_start  = mult_start_q;
  assign div_start   = div_start_q;
  assign hi_write    = hi_write_q;
  assign lo_write    = lo_write_q;
  assign hi_in       = hi_in_q;
  assign lo_in       = lo_in_q;
  assign op_done     = op_done_q;
  assign dbz_exc     = dbz_exc_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; the bench acts as both multiplier and divider.
module tb_muldiv_sequencer;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid, req_op;
  logic [W-1:0]   req_a, req_b;
  logic           req_ready, busy;
  logic [W-1:0]   op_a, op_b;
  logic           mult_start, div_start;
  logic           mult_done, div_done;
  logic [2*W-1:0] mult_result;
  logic [W-1:0]   div_quotient, div_remainder;
  logic           hi_write, lo_write;
  logic [W-1:0]   hi_in, lo_in;
  logic           op_done, dbz_exc, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ms_tot = 0, ds_tot = 0, hw_tot = 0, dbz_tot = 0;
  int ms0, ds0, hw0, dbz0;

  // {req_ready, busy, mult_start, div_start, hi_write, lo_write, op_done, dbz_exc, timeout_err}
  logic [8:0] flags;
  assign flags = {req_ready, busy, mult_start, div_start, hi_write, lo_write, op_done, dbz_exc, timeout_err};

  localparam logic [8:0] F_IDLE   = 9'b100000000;
  localparam logic [8:0] F_LMUL   = 9'b011000000;
  localparam logic [8:0] F_LDIV   = 9'b010100000;
  localparam logic [8:0] F_BUSY   = 9'b010000000;
  localparam logic [8:0] F_WB     = 9'b010011100;
  localparam logic [8:0] F_EXC    = 9'b010000010;
  localparam logic [8:0] F_TOIDLE = 9'b100000001;

  muldiv_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .busy(busy),
    .op_a(op_a), .op_b(op_b), .mult_start(mult_start), .div_start(div_start),
    .mult_done(mult_done), .mult_result(mult_result), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .hi_write(hi_write), .lo_write(lo_write), .hi_in(hi_in), .lo_in(lo_in),
    .op_done(op_done), .dbz_exc(dbz_exc), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mult_start) ms_tot++;
    if (div_start)  ds_tot++;
    if (hi_write)   hw_tot++;
    if (dbz_exc)    dbz_tot++;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic snap;
    ms0 = ms_tot; ds0 = ds_tot; hw0 = hw_tot; dbz0 = dbz_tot;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
    mult_done = 1'b0; div_done = 1'b0; mult_result = '0; div_quotient = '0; div_remainder = '0;
    tick; tick;
    reset = 1'b0;
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL reset_flags: got %b want %b", flags, F_IDLE); end
    n_checks++; if ({op_a, op_b, hi_in, lo_in} !== '0) begin n_fail++; $display("FAIL reset_data: op_a=%h op_b=%h hi_in=%h lo_in=%h want all 0", op_a, op_b, hi_in, lo_in); end
    // Done strobes in IDLE must not trigger anything
    snap;
    mult_done = 1'b1; div_done = 1'b1; mult_result = 64'h1234_5678_9abc_def0;
    tick;
    mult_done = 1'b0; div_done = 1'b0; mult_result = '0;
    tick;
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL idle_done_ignored: got %b want %b", flags, F_IDLE); end
    n_checks++; if (hw_tot - hw0 !== 0) begin n_fail++; $display("FAIL idle_done_nowrite: got %0d writes want 0", hw_tot - hw0); end
  endtask

  task automatic test_mult;
    snap;
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd7; req_b = 32'hFFFF_FFFD;
    tick;
    req_valid = 1'b0;
    n_checks++; if (flags !== F_LMUL) begin n_fail++; $display("FAIL mult_launch: got %b want %b", flags, F_LMUL); end
    n_checks++; if ({op_a, op_b} !== {32'd7, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL mult_operands: got %h %h want 00000007 fffffffd", op_a, op_b); end
    tick; tick; tick;
    n_checks++; if (flags !== F_BUSY) begin n_fail++; $display("FAIL mult_wait: got %b want %b", flags, F_BUSY); end
    tick;
    mult_done = 1'b1; mult_result = 64'hFFFF_FFFF_FFFF_FFEB;
    tick;
    mult_done = 1'b0; mult_result = '0;
    n_checks++; if (flags !== F_WB) begin n_fail++; $display("FAIL mult_wb_flags: got %b want %b", flags, F_WB); end
    n_checks++; if ({hi_in, lo_in} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_wb_data: got %h %h want ffffffff ffffffeb", hi_in, lo_in); end
    tick;
    n_checks++; if (flags !== F_IDLE || {hi_in, lo_in} !== '0) begin n_fail++; $display("FAIL mult_return: flags %b hi %h lo %h want %b 0 0", flags, hi_in, lo_in, F_IDLE); end
    n_checks++; if ({ms_tot - ms0, ds_tot - ds0, hw_tot - hw0} !== {32'd1, 32'd0, 32'd1}) begin n_fail++; $display("FAIL mult_counts: ms=%0d ds=%0d hw=%0d want 1 0 1", ms_tot - ms0, ds_tot - ds0, hw_tot - hw0); end
  endtask

  task automatic test_div;
    snap;
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd100; req_b = 32'd7;
    tick;
    req_valid = 1'b0;
    n_checks++; if (flags !== F_LDIV) begin n_fail++; $display("FAIL div_launch: got %b want %b", flags, F_LDIV); end
    tick;
    mult_done = 1'b1; mult_result = 64'hDEAD_BEEF_0BAD_F00D;
    tick;
    mult_done = 1'b0; mult_result = '0;
    n_checks++; if (flags !== F_BUSY) begin n_fail++; $display("FAIL div_ignores_mult_done: got %b want %b", flags, F_BUSY); end
    div_done = 1'b1; div_quotient = 32'd14; div_remainder = 32'd2;
    tick;
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    n_checks++; if (flags !== F_WB) begin n_fail++; $display("FAIL div_wb_flags: got %b want %b", flags, F_WB); end
    n_checks++; if ({hi_in, lo_in} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL div_wb_data: got %h %h want 00000002 0000000e", hi_in, lo_in); end
    tick;
    n_checks++; if ({ms_tot - ms0, ds_tot - ds0, hw_tot - hw0} !== {32'd0, 32'd1, 32'd1}) begin n_fail++; $display("FAIL div_counts: ms=%0d ds=%0d hw=%0d want 0 1 1", ms_tot - ms0, ds_tot - ds0, hw_tot - hw0); end
  endtask

  task automatic test_div_by_zero;
    snap;
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd5; req_b = 32'd0;
    tick;
    req_valid = 1'b0;
    n_checks++; if (flags !== F_BUSY) begin n_fail++; $display("FAIL dbz_launch: got %b want %b", flags, F_BUSY); end
    tick;
    n_checks++; if (flags !== F_EXC) begin n_fail++; $display("FAIL dbz_exc_cycle: got %b want %b", flags, F_EXC); end
    tick;
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL dbz_return: got %b want %b", flags, F_IDLE); end
    n_checks++; if ({ds_tot - ds0, hw_tot - hw0, dbz_tot - dbz0} !== {32'd0, 32'd0, 32'd1}) begin n_fail++; $display("FAIL dbz_counts: ds=%0d hw=%0d dbz=%0d want 0 0 1", ds_tot - ds0, hw_tot - hw0, dbz_tot - dbz0); end
  endtask

  task automatic test_back_to_back;
    snap;
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd3; req_b = 32'd4;
    tick;
    req_a = 32'd5; req_b = 32'd6;
    n_checks++; if (flags !== F_LMUL) begin n_fail++; $display("FAIL b2b_launch1: got %b want %b", flags, F_LMUL); end
    tick;
    mult_done = 1'b1; mult_result = 64'd12;
    tick;
    mult_done = 1'b0; mult_result = '0;
    n_checks++; if (flags !== F_WB || lo_in !== 32'd12 || op_a !== 32'd3) begin n_fail++; $display("FAIL b2b_wb1: flags %b lo %h op_a %h want %b 0000000c 00000003", flags, lo_in, op_a, F_WB); end
    tick;
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL b2b_idle: got %b want %b", flags, F_IDLE); end
    tick;
    req_valid = 1'b0;
    n_checks++; if (flags !== F_LMUL || op_a !== 32'd5 || op_b !== 32'd6) begin n_fail++; $display("FAIL b2b_launch2: flags %b op_a %h op_b %h want %b 5 6", flags, op_a, op_b, F_LMUL); end
    tick;
    mult_done = 1'b1; mult_result = 64'd30;
    tick;
    mult_done = 1'b0; mult_result = '0;
    n_checks++; if (flags !== F_WB || lo_in !== 32'd30) begin n_fail++; $display("FAIL b2b_wb2: flags %b lo %h want %b 0000001e", flags, lo_in, F_WB); end
    tick;
    n_checks++; if ({ms_tot - ms0, hw_tot - hw0} !== {32'd2, 32'd2}) begin n_fail++; $display("FAIL b2b_counts: ms=%0d hw=%0d want 2 2", ms_tot - ms0, hw_tot - hw0); end
  endtask

  task automatic test_reset_in_wait;
    snap;
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'd100; req_b = 32'd7;
    tick;
    req_valid = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    div_done = 1'b1; div_quotient = 32'd14; div_remainder = 32'd2;
    n_checks++; if (flags !== F_IDLE || op_a !== '0) begin n_fail++; $display("FAIL rst_wait_idle: flags %b op_a %h want %b 0", flags, op_a, F_IDLE); end
    tick;
    div_done = 1'b0; div_quotient = '0; div_remainder = '0;
    tick;
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL rst_wait_after_done: got %b want %b", flags, F_IDLE); end
    n_checks++; if (hw_tot - hw0 !== 0) begin n_fail++; $display("FAIL rst_wait_nowrite: got %0d writes want 0", hw_tot - hw0); end
  endtask

  task automatic test_timeout;
    snap;
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd9; req_b = 32'd9;
    tick;
    req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      n_checks++; if (flags !== F_BUSY) begin n_fail++; $display("FAIL timeout_wait%0d: got %b want %b", i, flags, F_BUSY); end
    end
    tick;
`ifdef MULDIV_TIMEOUT_EN
    n_checks++; if (flags !== F_TOIDLE) begin n_fail++; $display("FAIL timeout_pulse: got %b want %b", flags, F_TOIDLE); end
    tick;
    n_checks++; if (flags !== F_IDLE) begin n_fail++; $display("FAIL timeout_return: got %b want %b", flags, F_IDLE); end
`else
    for (int i = 0; i < 20; i++) tick;
    n_checks++; if (flags !== F_BUSY) begin n_fail++; $display("FAIL no_timeout_still_waiting: got %b want %b", flags, F_BUSY); end
    mult_done = 1'b1; mult_result = 64'd81;
    tick;
    mult_done = 1'b0; mult_result = '0;
    n_checks++; if (flags !== F_WB || lo_in !== 32'd81) begin n_fail++; $display("FAIL no_timeout_wb: flags %b lo %h want %b 00000051", flags, lo_in, F_WB); end
    tick;
`endif
    n_checks++; if (hw_tot - hw0 !== (flags === F_IDLE && dut.timeout_err === 1'b0 ? hw_tot - hw0 : -1)) begin n_fail++; $display("FAIL timeout_end_state: flags %b", flags); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_by_zero;
    test_back_to_back;
    test_reset_in_wait;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
